switch_mem_config: RTL
======================

Name: switch_mem_config

Overview:
- Parametrised configuration memory for the switch. It holds one destination-address entry per output port, written and read over the mem_en / mem_rd_wr / mem_add / mem_data bus.
- Successor to the fixed 8-bit, 4-entry config bus. Adds:
  - configurable data width, depth and read latency;
  - a pipelined read-data return path with a valid strobe;
  - per-entry programmed flags;
  - duplicate-address detection;
  - a write counter.
- Sits between the config agent and the switch routing logic. The routing logic consumes the flattened entry vector.

Parameters:
- DATA_WIDTH, 8, width of each address entry and of mem_data / mem_rd_data.
- ADDR_WIDTH, 2, entry index width; DEPTH = 2**ADDR_WIDTH entries.
- READ_LATENCY, 1, clock cycles from read sample to mem_rd_valid; legal range 1..4.
- RESET_VALUE, 0, value loaded into every entry on reset.

Ports:
- clock, input, 1, single clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high reset.
- mem_en, input, 1, access request; sampled on every posedge.
- mem_rd_wr, input, 1, access type: 1 = write, 0 = read; meaningful only when mem_en = 1.
- mem_add, input, ADDR_WIDTH, entry index.
- mem_data, input, DATA_WIDTH, write data.
- mem_rd_data, output, DATA_WIDTH, read return data.
- mem_rd_valid, output, 1, one-cycle strobe qualifying mem_rd_data.
- cfg_entries, output, DEPTH*DATA_WIDTH, flattened entries; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- cfg_valid, output, DEPTH, bit i set once entry i has been written since reset.
- dup_err, output, 1, high while two or more valid entries hold equal values.
- wr_count, output, 8, number of writes since reset; saturates at 255.

Behaviour:
- Reset (async assert, sync release):
  - all entries = RESET_VALUE; cfg_valid = 0; mem_rd_data = 0; mem_rd_valid = 0; dup_err = 0; wr_count = 0.
  - Read pipeline is flushed. A read in flight when reset asserts never returns.
- Write: mem_en=1, mem_rd_wr=1 at edge E.
  - entry[mem_add] <= mem_data and cfg_valid[mem_add] <= 1, both visible after E.
  - wr_count increments at E unless already 255.
  - Rewriting the same index overwrites the entry; cfg_valid stays 1.
- Read: mem_en=1, mem_rd_wr=0 at edge E.
  - entry[mem_add] as held before E is captured into stage 1.
  - mem_rd_data / mem_rd_valid appear after edge E+READ_LATENCY-1, i.e. READ_LATENCY=1 gives valid in the cycle following E.
  - Back-to-back reads: one result per cycle, in order, no bubbles.
  - Reading an unwritten entry returns RESET_VALUE with mem_rd_valid=1.
- Pipeline outputs:
  - mem_rd_valid is low in every cycle without a returning read.
  - mem_rd_data holds its last value when valid is low.
- Interleaving: a write followed by a read of the same index on the next edge returns the new data (single port, no bypass needed).
- Idle: mem_en=0 means no state change. mem_rd_wr, mem_add and mem_data are don't-care.
- dup_err:
  - Registered pairwise compare over entries where both cfg_valid bits are 1; RESET_VALUE entries that were never written are ignored.
  - Updated one edge after the entry change: a write at E is reflected in dup_err after E+1.
  - Clears the same way once the duplicate is overwritten.
- cfg_entries / cfg_valid are direct register outputs, with no extra latency beyond the write edge.
- Out-of-range index is impossible (DEPTH = 2**ADDR_WIDTH).

Decomposition:
- Package switch_mem_pkg:
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - MEM_WRITE = 1'b1 and MEM_READ = 1'b0 constants;
  - WR_COUNT_MAX = 8'hFF;
  - a packed struct typedef {en, rd_wr, add, data} for the request bus.
- One sub-module, mem_read_pipe: READ_LATENCY-deep data+valid shift pipeline with async reset flush.
- Entry array, valid flags, duplicate compare and counter stay in the top.

Test Plan:
- Reset then read all 4 entries (READ_LATENCY=1) -> mem_rd_data=0x00 each with mem_rd_valid one cycle after each read; cfg_valid=4'b0000; wr_count=0.
- Write 0x11,0x22,0x33,0x44 to indices 0..3, then back-to-back reads 3,2,1,0 -> returns 0x44,0x33,0x22,0x11 on consecutive cycles; cfg_valid=4'b1111; wr_count=4; cfg_entries=32'h44332211.
- Write 0x55 to index 0 and 0x55 to index 2 -> dup_err=1 one edge after the second write; then write 0x66 to index 2 -> dup_err=0 one edge later.
- READ_LATENCY=3, write 0xA5 to index 1, read index 1 on the next edge -> mem_rd_valid high exactly 3 cycles after the read edge, data 0xA5.
- Issue a read (READ_LATENCY=3), assert reset one cycle later for one cycle -> no mem_rd_valid ever appears; all outputs are at reset values while reset is high.
- 300 consecutive writes -> wr_count stops at 255 and stays there; one further write leaves it at 255.

Source files
------------

// File: rtl/switch_mem_pkg.sv
// Shared constants and request-bus type for the switch configuration memory.
package switch_mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;

    localparam logic       MEM_WRITE    = 1'b1;
    localparam logic       MEM_READ     = 1'b0;
    localparam logic [7:0] WR_COUNT_MAX = 8'hFF;

    typedef struct packed {
        logic                      en;
        logic                      rd_wr;
        logic [DEF_ADDR_WIDTH-1:0] add;
        logic [DEF_DATA_WIDTH-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-depth read-return pipeline; data only advances alongside its valid bit,
// so the output word holds its last value between returns.
module mem_read_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] data_r [LATENCY];
    logic [LATENCY-1:0]    valid_r;

    // Shift valid every cycle; move data only with a valid token
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
            end else begin
                data_r[0] <= data_r[0];
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    always_comb begin
        out_data  = data_r[LATENCY-1];
        out_valid = valid_r[LATENCY-1];
    end

endmodule

// File: rtl/switch_mem_config_checker.sv
// Structural invariants of the configuration memory, observed from its outputs.
module switch_mem_config_checker #(
    parameter int DEPTH        = 4,
    parameter int READ_LATENCY = 1
) (
    input logic             clock,
    input logic             reset,
    input logic [DEPTH-1:0] cfg_valid,
    input logic [7:0]       wr_count
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_range
        $error("READ_LATENCY must be within 1..4");
    end

    // A saturated write counter never leaves saturation outside reset
    a_count_sat: assert property (@(posedge clock) disable iff (reset)
        (wr_count == 8'hFF) |=> (wr_count == 8'hFF));

    // Programmed flags are sticky until reset
    a_valid_sticky: assert property (@(posedge clock) disable iff (reset)
        1'b1 |=> ((cfg_valid & $past(cfg_valid)) == $past(cfg_valid)));

endmodule

// File: rtl/switch_mem_config.sv
// Per-port destination-address configuration memory with pipelined reads,
// programmed flags, duplicate detection and a saturating write counter.
module switch_mem_config
    import switch_mem_pkg::*;
#(
    parameter int                       DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                       ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                       READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mem_en,
    input  logic                                mem_rd_wr,
    input  logic [ADDR_WIDTH-1:0]               mem_add,
    input  logic [DATA_WIDTH-1:0]               mem_data,
    output logic [DATA_WIDTH-1:0]               mem_rd_data,
    output logic                                mem_rd_valid,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] cfg_entries,
    output logic [(2**ADDR_WIDTH)-1:0]          cfg_valid,
    output logic                                dup_err,
    output logic [7:0]                          wr_count
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entry_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [7:0]            count_r;
    logic                  dup_r;
    logic                  dup_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Decode the access type and fetch the pre-edge word for a read
    always_comb begin
        wr_s      = mem_en && (mem_rd_wr == MEM_WRITE);
        rd_s      = mem_en && (mem_rd_wr == MEM_READ);
        rd_word_s = entry_r[mem_add];
    end

    // Entry storage and programmed flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= RESET_VALUE;
            end
        end else if (wr_s) begin
            entry_r[mem_add] <= mem_data;
            valid_r[mem_add] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Saturating write counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (wr_s && (count_r != WR_COUNT_MAX)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Pairwise compare, only between entries that have actually been programmed
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = i + 1; j < DEPTH; j++) begin
                dup_s = dup_s | (valid_r[i] & valid_r[j] & (entry_r[i] == entry_r[j]));
            end
        end
    end

    // Duplicate flag lags the entry change by one edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dup_r <= 1'b0;
        end else begin
            dup_r <= dup_s;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign cfg_entries[g*DATA_WIDTH +: DATA_WIDTH] = entry_r[g];
    end

    assign cfg_valid = valid_r;
    assign dup_err   = dup_r;
    assign wr_count  = count_r;

    mem_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_s),
        .in_data   (rd_word_s),
        .out_data  (mem_rd_data),
        .out_valid (mem_rd_valid)
    );

    switch_mem_config_checker #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (valid_r),
        .wr_count  (count_r)
    );

endmodule
